// File: rtl/traffic_sched.sv
// traffic_sched: two-way intersection controller with yellow and all-red clearance phases.
// Define PED_EN to add the pedestrian request input and the PED_WALK phase.
module traffic_sched #(
   parameter int unsigned CNT_W      = 8,
   parameter int unsigned YEL_TICKS  = 4,
   parameter int unsigned RED_TICKS  = 2,
   parameter int unsigned WALK_TICKS = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tick,
   input  logic [CNT_W-1:0] min_green,
   input  logic [CNT_W-1:0] max_green,
   input  logic             ns_req,
   input  logic             ew_req,
`ifdef PED_EN
   input  logic             ped_req,
`endif
   output logic [1:0]       ns_light,
   output logic [1:0]       ew_light,
   output logic             walk,
   output logic [2:0]       state_o
);

   typedef enum logic [2:0] {
      NS_GREEN  = 3'd0,
      NS_YELLOW = 3'd1,
      NS_RED    = 3'd2,
      EW_GREEN  = 3'd3,
      EW_YELLOW = 3'd4,
      EW_RED    = 3'd5,
      PED_WALK  = 3'd6
   } state_t;

   localparam logic [CNT_W-1:0] YEL_C  = CNT_W'(YEL_TICKS);
   localparam logic [CNT_W-1:0] RED_C  = CNT_W'(RED_TICKS);
   localparam logic [CNT_W-1:0] WALK_C = CNT_W'(WALK_TICKS);

   // Register holds the raw code so the unused code 7 stays representable and recoverable.
   logic [2:0]       state_q;
   state_t           state_d;
   state_t           cur;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic [CNT_W-1:0] elapsed, min_eff, phase_lim;
   logic             ns_pend_q, ns_pend_d;
   logic             ew_pend_q, ew_pend_d;
   logic             ped_dem;
   logic             phase_done;

`ifdef PED_EN
   logic ped_pend_q, ped_pend_d;
   logic ped_to_ns_q, ped_to_ns_d;
   assign ped_dem = ped_pend_q;
`else
   assign ped_dem = 1'b0;
`endif

   assign cur = state_t'(state_q);

   // Tick count including the current tick, saturating at all-ones.
   assign elapsed = (timer_q == '1) ? timer_q : timer_q + CNT_W'(1);

   always_comb begin
      min_eff = (min_green == '0) ? CNT_W'(1) : min_green;
      if (min_eff > max_green) min_eff = max_green;
   end

   always_comb begin
      phase_lim = '1;
      case (cur)
         NS_YELLOW, EW_YELLOW: phase_lim = YEL_C;
         NS_RED, EW_RED:       phase_lim = RED_C;
         PED_WALK:             phase_lim = WALK_C;
         default:              phase_lim = '1;
      endcase
   end

   assign phase_done = tick && (elapsed >= phase_lim);

   always_comb begin
      state_d   = cur;
      ns_pend_d = ns_pend_q | (ns_req & (cur != NS_GREEN));
      ew_pend_d = ew_pend_q | (ew_req & (cur != EW_GREEN));
`ifdef PED_EN
      ped_pend_d  = ped_pend_q | ped_req;
      ped_to_ns_d = ped_to_ns_q;
`endif
      case (cur)
         NS_GREEN:
            if (tick && (ew_pend_q || ped_dem) &&
                ((elapsed >= min_eff && !ns_req) || elapsed >= max_green))
               state_d = NS_YELLOW;
         NS_YELLOW: if (phase_done) state_d = NS_RED;
         NS_RED:    if (phase_done) state_d = ped_dem ? PED_WALK : EW_GREEN;
         EW_GREEN:
            if (tick && (ns_pend_q || ped_dem) &&
                ((elapsed >= min_eff && !ew_req) || elapsed >= max_green))
               state_d = EW_YELLOW;
         EW_YELLOW: if (phase_done) state_d = EW_RED;
         EW_RED:    if (phase_done) state_d = ped_dem ? PED_WALK : NS_GREEN;
`ifdef PED_EN
         PED_WALK:  if (phase_done) state_d = ped_to_ns_q ? NS_GREEN : EW_GREEN;
`endif
         default:   state_d = NS_RED;
      endcase

      if (state_d == NS_GREEN && cur != NS_GREEN) ns_pend_d = 1'b0;
      if (state_d == EW_GREEN && cur != EW_GREEN) ew_pend_d = 1'b0;
`ifdef PED_EN
      // Remember which green the interrupted red was heading for.
      if (state_d == PED_WALK && cur != PED_WALK) begin
         ped_pend_d  = 1'b0;
         ped_to_ns_d = (cur == EW_RED);
      end
`endif

      if (state_d != cur) timer_d = '0;
      else if (tick)      timer_d = elapsed;
      else                timer_d = timer_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= NS_RED;
         timer_q   <= '0;
         ns_pend_q <= 1'b0;
         ew_pend_q <= 1'b0;
`ifdef PED_EN
         ped_pend_q  <= 1'b0;
         ped_to_ns_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         ns_pend_q <= ns_pend_d;
         ew_pend_q <= ew_pend_d;
`ifdef PED_EN
         ped_pend_q  <= ped_pend_d;
         ped_to_ns_q <= ped_to_ns_d;
`endif
      end
   end

   always_comb begin
      ns_light = 2'b00;
      ew_light = 2'b00;
      case (cur)
         NS_GREEN:  ns_light = 2'b10;
         NS_YELLOW: ns_light = 2'b01;
         EW_GREEN:  ew_light = 2'b10;
         EW_YELLOW: ew_light = 2'b01;
         default: begin
            ns_light = 2'b00;
            ew_light = 2'b00;
         end
      endcase
   end

`ifdef PED_EN
   assign walk = (cur == PED_WALK);
`else
   assign walk = 1'b0;
`endif

   assign state_o = state_q;

endmodule

// File: tb/tb_traffic_sched.sv
// Directed bench for traffic_sched: reset, gap-out, max-out, green limits, tick gating, recovery.
module tb_traffic_sched;

   localparam logic [2:0] S_NSG = 3'd0, S_NSY = 3'd1, S_NSR = 3'd2,
                          S_EWG = 3'd3, S_EWY = 3'd4, S_EWR = 3'd5,
                          S_PED = 3'd6, S_BAD = 3'd7;
   localparam logic [1:0] R = 2'b00, Y = 2'b01, G = 2'b10;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       tick;
   logic [7:0] min_green, max_green;
   logic       ns_req, ew_req, ped_req;
   logic [1:0] ns_light, ew_light;
   logic       walk;
   logic [2:0] state_o;

   int vecs = 0;
   int errs = 0;

   traffic_sched #(
      .CNT_W(8), .YEL_TICKS(4), .RED_TICKS(2), .WALK_TICKS(6)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick     (tick),
      .min_green(min_green),
      .max_green(max_green),
      .ns_req   (ns_req),
      .ew_req   (ew_req),
`ifdef PED_EN
      .ped_req  (ped_req),
`endif
      .ns_light (ns_light),
      .ew_light (ew_light),
      .walk     (walk),
      .state_o  (state_o)
   );

   always #5 clk = ~clk;

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [2:0] st, input logic [1:0] ns,
                      input logic [1:0] ew, input logic wk);
      logic [7:0] obs, exp;
      obs = {state_o, ns_light, ew_light, walk};
      exp = {st, ns, ew, wk};
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: {state,ns,ew,walk} got %b expected %b", tag, obs, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; tick = 1'b1; min_green = 8'd3; max_green = 8'd10;
      ns_req = 1'b0; ew_req = 1'b0; ped_req = 1'b0;

      // Reset and idle rest in EW green
      cyc(2);
      chk("reset_hold", S_NSR, R, R, 1'b0);
      rst_n = 1'b1;
      cyc(1); chk("idle_red_t1", S_NSR, R, R, 1'b0);
      cyc(1); chk("idle_ewg", S_EWG, R, G, 1'b0);
      cyc(30); chk("idle_ewg_rest", S_EWG, R, G, 1'b0);

      // Asynchronous reset from green, then ns_req gap-out
      #3; rst_n = 1'b0;
      #1; chk("async_rst_green", S_NSR, R, R, 1'b0);
      cyc(1);
      rst_n = 1'b1; ns_req = 1'b1;
      cyc(1); chk("b_red_t1", S_NSR, R, R, 1'b0);
      ns_req = 1'b0;
      cyc(1); chk("b_ewg", S_EWG, R, G, 1'b0);
      cyc(2); chk("b_ewg_t2", S_EWG, R, G, 1'b0);
      cyc(1); chk("b_gapout_ewy", S_EWY, R, Y, 1'b0);
      cyc(3); chk("b_ewy_t3", S_EWY, R, Y, 1'b0);
      cyc(1); chk("b_ewr", S_EWR, R, R, 1'b0);
      cyc(1); chk("b_ewr_t1", S_EWR, R, R, 1'b0);
      cyc(1); chk("b_nsg", S_NSG, G, R, 1'b0);

      // tick gating: pending demand but no ticks
      tick = 1'b0; ew_req = 1'b1;
      cyc(1);
      ew_req = 1'b0;
      cyc(9); chk("c_notick_hold", S_NSG, G, R, 1'b0);
      tick = 1'b1;
      cyc(2); chk("c_nsg_t2", S_NSG, G, R, 1'b0);
      cyc(1); chk("c_gapout_nsy", S_NSY, Y, R, 1'b0);
      cyc(4); chk("c_nsr", S_NSR, R, R, 1'b0);
      cyc(2); chk("c_ewg", S_EWG, R, G, 1'b0);

      // Continuous demand both ways: max-out at 10
      ns_req = 1'b1; ew_req = 1'b1;
      cyc(9); chk("d_ewg_t9", S_EWG, R, G, 1'b0);
      cyc(1); chk("d_maxout_ewy", S_EWY, R, Y, 1'b0);
      cyc(4); chk("d_ewr", S_EWR, R, R, 1'b0);
      cyc(2); chk("d_nsg", S_NSG, G, R, 1'b0);
      cyc(9); chk("d_nsg_t9", S_NSG, G, R, 1'b0);
      cyc(1); chk("d_maxout_nsy", S_NSY, Y, R, 1'b0);
      cyc(4); chk("d_nsr", S_NSR, R, R, 1'b0);
      cyc(2); chk("d_ewg", S_EWG, R, G, 1'b0);

      // min_green=0 acts as 1; min_green>max_green uses max_green
      min_green = 8'd0; ew_req = 1'b0;
      cyc(1); chk("e_min0_ewy", S_EWY, R, Y, 1'b0);
      cyc(4); chk("e_ewr", S_EWR, R, R, 1'b0);
      cyc(2); chk("e_nsg", S_NSG, G, R, 1'b0);
      min_green = 8'd12; max_green = 8'd5; ew_req = 1'b1;
      cyc(4); chk("e_nsg_t4", S_NSG, G, R, 1'b0);
      cyc(1); chk("e_max5_nsy", S_NSY, Y, R, 1'b0);

      // Reset mid-yellow, then illegal code recovery
      cyc(2); chk("f_nsy_t2", S_NSY, Y, R, 1'b0);
      #3; rst_n = 1'b0;
      #1; chk("f_async_rst_yel", S_NSR, R, R, 1'b0);
      cyc(1);
      rst_n = 1'b1; min_green = 8'd3; max_green = 8'd10;
      ns_req = 1'b0; ew_req = 1'b0;
      cyc(1); chk("f_red_t1", S_NSR, R, R, 1'b0);
      force dut.state_q = 3'd7;
      #1; chk("f_code7_dark", S_BAD, R, R, 1'b0);
      release dut.state_q;
      cyc(1); chk("f_code7_recover", S_NSR, R, R, 1'b0);
      cyc(2); chk("f_recover_ewg", S_EWG, R, G, 1'b0);

`ifdef PED_EN
      // Pedestrian phase inserted after NS clearance, then EW green
      ns_req = 1'b1;
      cyc(1);
      ns_req = 1'b0;
      cyc(2); chk("g_ewy", S_EWY, R, Y, 1'b0);
      cyc(4); chk("g_ewr", S_EWR, R, R, 1'b0);
      cyc(2); chk("g_nsg", S_NSG, G, R, 1'b0);
      ped_req = 1'b1;
      cyc(1);
      ped_req = 1'b0;
      cyc(2); chk("g_ped_nsy", S_NSY, Y, R, 1'b0);
      cyc(4); chk("g_nsr", S_NSR, R, R, 1'b0);
      cyc(2); chk("g_walk", S_PED, R, R, 1'b1);
      cyc(5); chk("g_walk_t5", S_PED, R, R, 1'b1);
      cyc(1); chk("g_walk_ewg", S_EWG, R, G, 1'b0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/traffic_sched.md
TRAFFIC_SCHED -- requirements
Module: traffic_sched

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- CNT_W, 8, width of the dwell timer and green-limit inputs.
- YEL_TICKS, 4, yellow duration in ticks.
- RED_TICKS, 2, all-red clearance duration in ticks.
- WALK_TICKS, 6, pedestrian walk duration in ticks.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- tick  in  1  single-cycle timebase enable; timers advance only when tick=1.
- min_green  in  CNT_W  minimum green dwell, in ticks.
- max_green  in  CNT_W  maximum green dwell when opposing demand exists.
- ns_req  in  1  NS vehicle demand, level.
- ew_req  in  1  EW vehicle demand, level.
- ped_req  in  1  pedestrian button; present only with PED_EN.
- ns_light  out  2  00=red, 01=yellow, 10=green.
- ew_light  out  2  same encoding as ns_light.
- walk  out  1  pedestrian walk indication.
- state_o  out  3  current state code, for debug.

Function
REQ-003 States SHALL be NS_GREEN=0, NS_YELLOW=1, NS_RED=2, EW_GREEN=3, EW_YELLOW=4, EW_RED=5, PED_WALK=6; code 7 SHALL recover to NS_RED on the next clock.
REQ-004 Outputs SHALL be a Moore decode of the state register only, with no combinational input-to-output path. In *_RED and PED_WALK both lights are 00. walk is 1 only in PED_WALK.
REQ-005 The timer SHALL clear to 0 on every state change, increment on each tick while the state is held, and saturate at all-ones.
REQ-006 ns_req and ew_req SHALL set sticky flags ns_pend and ew_pend. A flag SHALL clear on entry to its own green. A request asserted while its own direction is green SHALL NOT set the flag.
REQ-007 NS_GREEN SHALL go to NS_YELLOW when ew_pend=1 and either of these holds:
- timer>=min_green and ns_req=0 (gap-out);
- timer>=max_green (max-out).
With ew_pend=0 the state SHALL rest in NS_GREEN indefinitely. EW_GREEN SHALL behave symmetrically.
REQ-008 A min_green value of 0 SHALL be treated as 1. If min_green>max_green, max_green SHALL govern.
REQ-009 *_YELLOW SHALL last exactly YEL_TICKS ticks. *_RED SHALL last exactly RED_TICKS ticks, then enter the opposing green.
REQ-010 A state change SHALL occur on the clock edge where tick=1 and the count condition becomes satisfied. With tick held at 0, no state SHALL change.
REQ-011 min_green and max_green SHALL be sampled continuously. A change mid-green takes effect on the next comparison.

Reset
REQ-012 During rst_n=0 the block SHALL hold state=NS_RED, timer=0, ns_pend=ew_pend=0 (and ped_pend=0 when present).
REQ-013 During rst_n=0 the outputs SHALL be ns_light=00, ew_light=00, walk=0.
REQ-014 After reset release the block SHALL enter EW_GREEN after RED_TICKS ticks; no green SHALL ever be adjacent to the other green without a yellow and a red.
REQ-015 Reset asserted mid-phase SHALL force all lights to red immediately and asynchronously.

Configuration
REQ-016 With PED_EN defined, the ped_req port and the sticky flag ped_pend SHALL exist. ped_pend clears on PED_WALK entry.
REQ-017 With PED_EN defined, a *_RED state whose timer expires while ped_pend=1 SHALL go to PED_WALK for WALK_TICKS ticks. It SHALL then enter the green that *_RED would have entered.
REQ-018 With PED_EN defined, ped_pend=1 SHALL count as opposing demand for gap-out and max-out.
REQ-019 Without PED_EN, the ped_req port SHALL be absent, walk SHALL be tied to 0, and state 6 SHALL be treated as illegal (REQ-003 recovery).

Verification
REQ-020 Reset, then tick every cycle with no requests -> NS_RED for 2 ticks, then EW_GREEN held forever with ew_light=10 and ns_light=00.
REQ-021 In EW_GREEN with min_green=3, max_green=10, pulse ns_req, ew_req=0 -> EW_YELLOW after 3 ticks, then 4 ticks yellow, 2 ticks red, then NS_GREEN.
REQ-022 ns_req held with ew_req=1 continuously, min_green=3, max_green=10 -> max-out at timer=10 each green; phases alternate.
REQ-023 min_green=0 and min_green=12>max_green=5 -> exits at 1 and 5 ticks respectively.
REQ-024 With PED_EN, pulse ped_req during NS_GREEN -> yellow, red, 6 ticks walk=1 with both lights 00, then EW_GREEN.
REQ-025 rst_n pulsed low mid-yellow, and state forced to 7 -> all lights 00 immediately; state 7 reaches NS_RED within 1 clock.
